// File: rtl/opl2_bus_writer.sv
// ---------------------------------------------------------------------------
// opl2_bus_writer
//
// Turns OPL2 register-write requests (register index + value) into the
// two-phase host-bus sequence the chip expects: an address-port write,
// a settling wait, a data-port write, then a longer settling wait. All
// bus pins come straight from flops.
//
// Parameters
//   WR_PULSE_CYCLES   clk cycles wr_n/cs_n are held low per bus write (1..255)
//   ADDR_WAIT_CYCLES  idle cycles after the address-port write    (1..255)
//   DATA_WAIT_CYCLES  idle cycles after the data-port write       (1..255)
//
// Ports
//   clk          single clock, all state changes on posedge
//   reset        asynchronous, active-high reset
//   req_valid    register-write request present
//   req_ready    request accepted when req_valid && req_ready at posedge clk
//   req_address  OPL2 register index
//   req_data     value for that register
//   cs_n         chip select, active low
//   wr_n         write strobe, active low
//   rd_n         read strobe, always 1
//   address      bus A0: 0 = address port, 1 = data port
//   dout         bus write data
//   busy         sequence in progress or a request is buffered
//
// Build option
//   OPL2_BUS_WRITER_FIFO_EN  when defined, a 4-entry request FIFO sits in
//                            front of the sequencer and req_ready = !full.
//                            When undefined there is no buffer and
//                            req_ready is high only in IDLE or in the last
//                            DATA_WAIT cycle.
// ---------------------------------------------------------------------------
module opl2_bus_writer #(
    parameter int unsigned WR_PULSE_CYCLES  = 2,
    parameter int unsigned ADDR_WAIT_CYCLES = 12,
    parameter int unsigned DATA_WAIT_CYCLES = 84
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_address,
    input  logic [7:0] req_data,
    output logic       cs_n,
    output logic       wr_n,
    output logic       rd_n,
    output logic       address,
    output logic [7:0] dout,
    output logic       busy
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] ADDR_WR   = 3'd1;
    localparam logic [2:0] ADDR_WAIT = 3'd2;
    localparam logic [2:0] DATA_WR   = 3'd3;
    localparam logic [2:0] DATA_WAIT = 3'd4;

    // Counters count down to zero, so each phase loads its length minus one.
    localparam logic [7:0] WR_LOAD        = 8'(WR_PULSE_CYCLES - 1);
    localparam logic [7:0] ADDR_WAIT_LOAD = 8'(ADDR_WAIT_CYCLES - 1);
    localparam logic [7:0] DATA_WAIT_LOAD = 8'(DATA_WAIT_CYCLES - 1);

    logic [2:0] state;
    logic [7:0] counter;
    logic [7:0] data_q;
    logic       rd_n_q;

    logic       can_take;
    logic       take;
    logic       pending;
    logic [7:0] next_address;
    logic [7:0] next_data;

    // The sequencer can start a new write from IDLE or straight out of the
    // last DATA_WAIT cycle, which gives back-to-back writes no extra gap.
    assign can_take = (state == IDLE) ||
                      ((state == DATA_WAIT) && (counter == 8'd0));

`ifdef OPL2_BUS_WRITER_FIFO_EN
    logic [15:0] fifo_mem [4];
    logic [1:0]  fifo_rd_ptr;
    logic [1:0]  fifo_wr_ptr;
    logic [2:0]  fifo_count;
    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        bypass;
    logic        fifo_push;
    logic        fifo_pop;

    assign fifo_empty = (fifo_count == 3'd0);
    assign fifo_full  = (fifo_count == 3'd4);
    assign req_ready  = !reset && !fifo_full;
    assign accept     = req_valid && req_ready;

    // An empty FIFO is skipped when the sequencer is free so a request still
    // reaches the bus one edge after it is accepted.
    assign fifo_pop   = can_take && !fifo_empty;
    assign bypass     = can_take && fifo_empty && accept;
    assign fifo_push  = accept && !bypass;
    assign take       = fifo_pop || bypass;
    assign pending    = !fifo_empty;

    assign next_address = fifo_empty ? req_address : fifo_mem[fifo_rd_ptr][15:8];
    assign next_data    = fifo_empty ? req_data    : fifo_mem[fifo_rd_ptr][7:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_rd_ptr <= 2'd0;
            fifo_wr_ptr <= 2'd0;
            fifo_count  <= 3'd0;
        end else begin
            if (fifo_push) begin
                fifo_wr_ptr <= fifo_wr_ptr + 2'd1;
            end
            if (fifo_pop) begin
                fifo_rd_ptr <= fifo_rd_ptr + 2'd1;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_mem[fifo_wr_ptr] <= {req_address, req_data};
        end
    end
`else
    assign req_ready    = !reset && can_take;
    assign take         = req_valid && can_take;
    assign pending      = 1'b0;
    assign next_address = req_address;
    assign next_data    = req_data;
`endif

    assign busy = (state != IDLE) || pending;
    assign rd_n = rd_n_q;

    // Reads are never issued; rd_n is still a flop so every bus pin is registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_n_q <= 1'b1;
        end else begin
            rd_n_q <= 1'b1;
        end
    end

    // Sequencer. address/dout are only loaded on entry to a write phase,
    // so they stay stable for the whole time wr_n is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            counter <= 8'd0;
            cs_n    <= 1'b1;
            wr_n    <= 1'b1;
            address <= 1'b0;
            dout    <= 8'd0;
            data_q  <= 8'd0;
        end else if (take) begin
            state   <= ADDR_WR;
            counter <= WR_LOAD;
            cs_n    <= 1'b0;
            wr_n    <= 1'b0;
            address <= 1'b0;
            dout    <= next_address;
            data_q  <= next_data;
        end else begin
            case (state)
                IDLE: begin
                    counter <= 8'd0;
                end
                ADDR_WR: begin
                    if (counter == 8'd0) begin
                        state   <= ADDR_WAIT;
                        counter <= ADDR_WAIT_LOAD;
                        cs_n    <= 1'b1;
                        wr_n    <= 1'b1;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                ADDR_WAIT: begin
                    if (counter == 8'd0) begin
                        state   <= DATA_WR;
                        counter <= WR_LOAD;
                        cs_n    <= 1'b0;
                        wr_n    <= 1'b0;
                        address <= 1'b1;
                        dout    <= data_q;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                DATA_WR: begin
                    if (counter == 8'd0) begin
                        state   <= DATA_WAIT;
                        counter <= DATA_WAIT_LOAD;
                        cs_n    <= 1'b1;
                        wr_n    <= 1'b1;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                DATA_WAIT: begin
                    if (counter == 8'd0) begin
                        state <= IDLE;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    counter <= 8'd0;
                    cs_n    <= 1'b1;
                    wr_n    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_opl2_bus_writer.sv
// ---------------------------------------------------------------------------
// tb_opl2_bus_writer
//
// Directed bench for opl2_bus_writer. One instance uses the default timing,
// a second uses 1/1/1 timing for the minimum-length sequence. Expected bus
// values per cycle are hand-derived from the phase lengths.
// ---------------------------------------------------------------------------
module tb_opl2_bus_writer;

    logic       clk = 1'b0;
    logic       reset;

    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_address;
    logic [7:0] req_data;
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       address;
    logic [7:0] dout;
    logic       busy;

    logic       f_req_valid;
    logic       f_req_ready;
    logic [7:0] f_req_address;
    logic [7:0] f_req_data;
    logic       f_cs_n;
    logic       f_wr_n;
    logic       f_rd_n;
    logic       f_address;
    logic [7:0] f_dout;
    logic       f_busy;

    always #5 clk = ~clk;

    opl2_bus_writer dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_address (req_address),
        .req_data    (req_data),
        .cs_n        (cs_n),
        .wr_n        (wr_n),
        .rd_n        (rd_n),
        .address     (address),
        .dout        (dout),
        .busy        (busy)
    );

    opl2_bus_writer #(
        .WR_PULSE_CYCLES  (1),
        .ADDR_WAIT_CYCLES (1),
        .DATA_WAIT_CYCLES (1)
    ) dut_fast (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (f_req_valid),
        .req_ready   (f_req_ready),
        .req_address (f_req_address),
        .req_data    (f_req_data),
        .cs_n        (f_cs_n),
        .wr_n        (f_wr_n),
        .rd_n        (f_rd_n),
        .address     (f_address),
        .dout        (f_dout),
        .busy        (f_busy)
    );

    // With the FIFO a held-valid request would be pushed every cycle, so the
    // second request is offered for exactly one edge instead of until the
    // sequencer frees up.
`ifdef OPL2_BUS_WRITER_FIFO_EN
    localparam int   B2B_DROP         = 2;
    localparam int   FAST_DROP        = 2;
    localparam logic READY_WHILE_BUSY = 1'b1;
`else
    localparam int   B2B_DROP         = 101;
    localparam int   FAST_DROP        = 5;
    localparam logic READY_WHILE_BUSY = 1'b0;
`endif

    int unsigned check_count = 0;
    int unsigned pass_count  = 0;

    logic [31:0] bus_trace  [0:255];
    logic        cs_trace   [0:255];
    logic        busy_trace [0:255];
    logic        ready_trace[0:255];
    logic [31:0] fast_trace [0:15];
    logic        fast_busy  [0:15];

    logic [15:0] wr_log [$];
    int unsigned stable_violations = 0;
    logic        prev_wr    = 1'b1;
    logic        prev_fwr   = 1'b1;
    logic        prev_a0    = 1'b0;
    logic        prev_fa0   = 1'b0;
    logic [7:0]  prev_dout  = 8'd0;
    logic [7:0]  prev_fdout = 8'd0;
    logic        prev_cs    = 1'b1;
    logic [7:0]  log_addr   = 8'd0;

    logic [7:0]  fifo_addr [6] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [7:0]  fifo_data [6] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
    logic        fifo_ready_exp [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic        fifo_ready_seen [6];

    function automatic logic [31:0] busWord(input logic cs, input logic wr,
                                            input logic a0, input logic [7:0] d);
        return {21'd0, cs, wr, a0, d};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Presents a request (caller is at a negedge), waits a bounded time for
    // ready, and returns just after the accepting edge.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] d, input logic hold);
        int waited = 0;
        req_address = a;
        req_data    = d;
        req_valid   = 1'b1;
        #1;
        while (!req_ready && waited < 1000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput($sformatf("accept_%02h", a), req_ready, 1);
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    // Cycle k is sampled on the negedge following the k-th edge after acceptance.
    task automatic captureCycles(input int n, input int drop_at);
        for (int k = 1; k <= n; k++) begin
            @(negedge clk);
            bus_trace[k]   = busWord(cs_n, wr_n, address, dout);
            cs_trace[k]    = cs_n;
            busy_trace[k]  = busy;
            ready_trace[k] = req_ready;
            if (k == drop_at) req_valid = 1'b0;
        end
    endtask

    // Default timing: addr write cycles 1-2, wait 3-14, data write 15-16, wait 17-100.
    task automatic checkWriteTrace(input logic [7:0] a, input logic [7:0] d,
                                   input int base, input string tag);
        int lows = 0;
        checkOutput($sformatf("%s_c1", tag),   bus_trace[base + 1],   busWord(0, 0, 0, a));
        checkOutput($sformatf("%s_c2", tag),   bus_trace[base + 2],   busWord(0, 0, 0, a));
        checkOutput($sformatf("%s_c3", tag),   bus_trace[base + 3],   busWord(1, 1, 0, a));
        checkOutput($sformatf("%s_c14", tag),  bus_trace[base + 14],  busWord(1, 1, 0, a));
        checkOutput($sformatf("%s_c15", tag),  bus_trace[base + 15],  busWord(0, 0, 1, d));
        checkOutput($sformatf("%s_c16", tag),  bus_trace[base + 16],  busWord(0, 0, 1, d));
        checkOutput($sformatf("%s_c17", tag),  bus_trace[base + 17],  busWord(1, 1, 1, d));
        checkOutput($sformatf("%s_c100", tag), bus_trace[base + 100], busWord(1, 1, 1, d));
        checkOutput($sformatf("%s_busy100", tag), busy_trace[base + 100], 1);
        for (int k = base + 1; k <= base + 100; k++) begin
            if (!cs_trace[k]) lows++;
        end
        checkOutput($sformatf("%s_cs_low_cycles", tag), lows, 4);
    endtask

    task automatic checkSingleWrite(input logic [7:0] a, input logic [7:0] d, input string tag);
        applyStimulus(a, d, 1'b0);
        captureCycles(101, 0);
        checkWriteTrace(a, d, 0, tag);
        checkOutput($sformatf("%s_busy101", tag), busy_trace[101], 0);
    endtask

    // Bus monitor: dout/A0 must not move while wr_n stays low; completed
    // address+data pairs are logged in bus order.
    always @(negedge clk) begin
        if (!prev_wr && !wr_n && (dout !== prev_dout || address !== prev_a0))
            stable_violations++;
        if (!prev_fwr && !f_wr_n && (f_dout !== prev_fdout || f_address !== prev_fa0))
            stable_violations++;
        if (prev_cs && !cs_n) begin
            if (!address) log_addr = dout;
            else wr_log.push_back({log_addr, dout});
        end
        prev_wr    = wr_n;
        prev_fwr   = f_wr_n;
        prev_a0    = address;
        prev_fa0   = f_address;
        prev_dout  = dout;
        prev_fdout = f_dout;
        prev_cs    = cs_n;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lows;
        int waited;

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_address   = 8'd0;
        req_data      = 8'd0;
        f_req_valid   = 1'b0;
        f_req_address = 8'd0;
        f_req_data    = 8'd0;
        repeat (3) @(negedge clk);

        checkOutput("reset_cs_n",      cs_n,      1);
        checkOutput("reset_wr_n",      wr_n,      1);
        checkOutput("reset_rd_n",      rd_n,      1);
        checkOutput("reset_address",   address,   0);
        checkOutput("reset_dout",      dout,      0);
        checkOutput("reset_busy",      busy,      0);
        checkOutput("reset_req_ready", req_ready, 0);

        // First request offered as reset releases, taken on the first edge.
        reset = 1'b0;
        checkSingleWrite(8'h20, 8'h01, "single");

        // Back-to-back: second ADDR_WR immediately after the first DATA_WAIT.
        wr_log.delete();
        applyStimulus(8'hA0, 8'h44, 1'b1);
        req_address = 8'hB0;
        req_data    = 8'h32;
        captureCycles(201, B2B_DROP);
        checkWriteTrace(8'hA0, 8'h44, 0,   "b2b_first");
        checkWriteTrace(8'hB0, 8'h32, 100, "b2b_second");
        checkOutput("b2b_busy200",    busy_trace[200], 1);
        checkOutput("b2b_busy201",    busy_trace[201], 0);
        checkOutput("b2b_ready_busy", ready_trace[50], READY_WHILE_BUSY);
        checkOutput("b2b_log_len",    wr_log.size(),   2);
        checkOutput("b2b_log0",       wr_log[0],       16'hA044);
        checkOutput("b2b_log1",       wr_log[1],       16'hB032);

        // Reset in the middle of the data-phase write.
        applyStimulus(8'h40, 8'h3F, 1'b0);
        captureCycles(15, 0);
        checkOutput("rst_in_data_wr", bus_trace[15], busWord(0, 0, 1, 8'h3F));
        #1 reset = 1'b1;
        #1;
        checkOutput("rst_abort_wr_n",  wr_n,      1);
        checkOutput("rst_abort_cs_n",  cs_n,      1);
        checkOutput("rst_abort_dout",  dout,      0);
        checkOutput("rst_abort_busy",  busy,      0);
        checkOutput("rst_abort_ready", req_ready, 0);
        @(negedge clk);
        reset = 1'b0;
        captureCycles(20, 0);
        lows = 0;
        for (int k = 1; k <= 20; k++) begin
            if (!cs_trace[k]) lows++;
        end
        checkOutput("rst_no_activity", lows, 0);
        checkOutput("rst_idle_busy",   busy_trace[20], 0);
        checkSingleWrite(8'h60, 8'hF0, "post_reset");

        // Minimum timing: 4-cycle write, then a back-to-back second write.
        f_req_address = 8'h11;
        f_req_data    = 8'h22;
        f_req_valid   = 1'b1;
        #1;
        checkOutput("fast_ready", f_req_ready, 1);
        @(posedge clk);
        #1;
        f_req_address = 8'h33;
        f_req_data    = 8'h44;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            fast_trace[k] = busWord(f_cs_n, f_wr_n, f_address, f_dout);
            fast_busy[k]  = f_busy;
            if (k == FAST_DROP) f_req_valid = 1'b0;
        end
        checkOutput("fast_c1",    fast_trace[1], busWord(0, 0, 0, 8'h11));
        checkOutput("fast_c2",    fast_trace[2], busWord(1, 1, 0, 8'h11));
        checkOutput("fast_c3",    fast_trace[3], busWord(0, 0, 1, 8'h22));
        checkOutput("fast_c4",    fast_trace[4], busWord(1, 1, 1, 8'h22));
        checkOutput("fast_busy4", fast_busy[4],  1);
        checkOutput("fast_c5",    fast_trace[5], busWord(0, 0, 0, 8'h33));
        checkOutput("fast_c7",    fast_trace[7], busWord(0, 0, 1, 8'h44));
        checkOutput("fast_busy8", fast_busy[8],  1);
        checkOutput("fast_busy9", fast_busy[9],  0);
        checkOutput("fast_rd_n",  f_rd_n,        1);

`ifdef OPL2_BUS_WRITER_FIFO_EN
        // Six requests on consecutive cycles: one in flight plus four buffered.
        wr_log.delete();
        for (int i = 0; i < 6; i++) begin
            req_valid   = 1'b1;
            req_address = fifo_addr[i];
            req_data    = fifo_data[i];
            #1;
            fifo_ready_seen[i] = req_ready;
            @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fifo_ready%0d", i), fifo_ready_seen[i], fifo_ready_exp[i]);
        end
        waited = 0;
        #1;
        while (!req_ready && waited < 2000) begin
            @(negedge clk);
            #1;
            waited++;
        end
        checkOutput("fifo_last_accept", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        waited = 0;
        while (busy && waited < 1000) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("fifo_drained", busy, 0);
        checkOutput("fifo_log_len", wr_log.size(), 6);
        for (int i = 0; i < 6; i++) begin
            checkOutput($sformatf("fifo_log%0d", i), wr_log[i], {fifo_addr[i], fifo_data[i]});
        end
`endif

        checkOutput("dout_stable_during_wr", stable_violations, 0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
